// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner with PWM brightness and frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter bit SEL_ACTIVE_LOW = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [4*NUM_DIGITS-1:0] disp_data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [3:0]              brightness,
  input  logic                    update,
  output logic                    pending,
  output logic [NUM_DIGITS-1:0]   SEL,
  output logic [7:0]              SEG,
  output logic                    frame_done
);

  localparam int DIV  = CLK_FREQ_HZ / SCAN_HZ;
  localparam int SUB  = DIV / 16;
  localparam int DIVW = $clog2(DIV);
  localparam int SUBW = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int IDXW = $clog2(NUM_DIGITS);

  localparam logic [DIVW-1:0]       DIV_LAST = DIVW'(DIV - 1);
  localparam logic [SUBW-1:0]       SUB_LAST = SUBW'(SUB - 1);
  localparam logic [IDXW-1:0]       IDX_LAST = IDXW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF  = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [DIVW-1:0]         div_cnt_q, div_cnt_d;
  logic [SUBW-1:0]         sub_cnt_q, sub_cnt_d;
  logic [3:0]              pwm_cnt_q, pwm_cnt_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pending_q, pending_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]              seg_q, seg_d;

  logic                    slot_end, sub_end, wrap, blank;
  logic [3:0]              nib;
  logic [6:0]              seg_lo;
  logic [7:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   sel_on;

  // Active-low a..g patterns for hex 0..F; dp is handled separately.
  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0: seg_code = 7'h40;  4'h1: seg_code = 7'h79;
      4'h2: seg_code = 7'h24;  4'h3: seg_code = 7'h30;
      4'h4: seg_code = 7'h19;  4'h5: seg_code = 7'h12;
      4'h6: seg_code = 7'h02;  4'h7: seg_code = 7'h78;
      4'h8: seg_code = 7'h00;  4'h9: seg_code = 7'h10;
      4'hA: seg_code = 7'h08;  4'hB: seg_code = 7'h03;
      4'hC: seg_code = 7'h46;  4'hD: seg_code = 7'h21;
      4'hE: seg_code = 7'h06;  default: seg_code = 7'h0E;
    endcase
  endfunction

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  zero_run;

  // A digit is blanked when it and every digit above it hold zero; digit 0 never is.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run & (act_data_q[4*k +: 4] == 4'h0);
      blank_mask[k] = zero_run;
    end
    blank = blank_mask[idx_q];
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    slot_end  = (div_cnt_q == DIV_LAST);
    sub_end   = (sub_cnt_q == SUB_LAST);
    wrap      = slot_end && (idx_q == IDX_LAST);

    div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
    sub_cnt_d = (slot_end || sub_end) ? '0 : sub_cnt_q + 1'b1;
    pwm_cnt_d = slot_end ? 4'd0 : (sub_end ? pwm_cnt_q + 4'd1 : pwm_cnt_q);
    idx_d     = slot_end ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;

    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pending_d   = pending_q;
    // An update landing on the wrap edge wins and waits for the following wrap.
    if (update) begin
      pend_data_d = disp_data;
      pend_dp_d   = dp_mask;
      pending_d   = 1'b1;
    end else if (wrap && pending_q) begin
      act_data_d = pend_data_q;
      act_dp_d   = pend_dp_q;
      pending_d  = 1'b0;
    end
    frame_done_d = wrap;

    nib     = act_data_q[{idx_q, 2'b00} +: 4];
    seg_lo  = blank ? 7'h7F : seg_code(nib);
    seg_raw = {~act_dp_q[idx_q], seg_lo};
    seg_d   = SEG_ACTIVE_LOW ? seg_raw : ~seg_raw;

    sel_on = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    if (pwm_cnt_q > brightness) sel_on = '0;
    sel_d = SEL_ACTIVE_LOW ? ~sel_on : sel_on;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt_q    <= '0;
      sub_cnt_q    <= '0;
      pwm_cnt_q    <= 4'd0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sel_q        <= SEL_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      div_cnt_q    <= div_cnt_d;
      sub_cnt_q    <= sub_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;
  assign SEL        = sel_q;
  assign SEG        = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, DIV=32, sub-slot of 2 cycles.
// Blanking expectations follow SEG7_LZB_EN so the bench matches either build.
module tb_seg7_scan_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] disp_data;
  logic [3:0]  dp_mask;
  logic [3:0]  brightness;
  logic        update;
  logic        pending;
  logic [3:0]  SEL;
  logic [7:0]  SEG;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int act_cnt;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .CLK_FREQ_HZ(1600), .SCAN_HZ(50),
    .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .disp_data(disp_data), .dp_mask(dp_mask),
    .brightness(brightness), .update(update), .pending(pending),
    .SEL(SEL), .SEG(SEG), .frame_done(frame_done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_update(input logic [15:0] data, input logic [3:0] dp);
    disp_data = data;
    dp_mask   = dp;
    update    = 1'b1;
    step();
    update    = 1'b0;
  endtask

  // Sample the middle of digit k's slot in the frame that starts at wrap_edge.
  task automatic chk_digit(input int wrap_edge, input int k, input logic [7:0] exp_seg);
    logic [3:0] one;
    one = 4'b0001;
    run_to(wrap_edge + 1 + 32 * k + 8);
    check_eq($sformatf("sel_d%0d", k), {28'd0, SEL}, {28'd0, one << k});
    check_eq($sformatf("seg_d%0d", k), {24'd0, SEG}, {24'd0, exp_seg});
  endtask

  initial begin
    logic [3:0] one;
    one        = 4'b0001;
    Reset_n    = 1'b0;
    disp_data  = '0;
    dp_mask    = '0;
    brightness = 4'd15;
    update     = 1'b0;
    step();
    step();
    check_eq("rst_sel", {28'd0, SEL}, 32'h0);
    check_eq("rst_seg", {24'd0, SEG}, 32'hFF);
    check_eq("rst_pending", {31'd0, pending}, 32'h0);
    check_eq("rst_frame_done", {31'd0, frame_done}, 32'h0);

    Reset_n = 1'b1;
    cyc     = 0;
    // Two full frames of zeros: SEL walks 0001..1000, 32 cycles per digit.
    for (int e = 1; e <= 256; e++) begin
      step();
      check_eq("scan_sel", {28'd0, SEL}, {28'd0, one << (((e - 1) / 32) % 4)});
      check_eq("scan_seg", {24'd0, SEG}, 32'hC0);
      check_eq("scan_fd", {31'd0, frame_done}, {31'd0, (e % 128) == 0});
    end

    run_to(300);
    do_update(16'h1A3F, 4'b0100);
    check_eq("upd_pending", {31'd0, pending}, 32'h1);
    run_to(383);
    check_eq("upd_pending_hold", {31'd0, pending}, 32'h1);
    step();
    check_eq("upd_pending_clr", {31'd0, pending}, 32'h0);
    check_eq("upd_fd", {31'd0, frame_done}, 32'h1);
    chk_digit(384, 0, 8'h8E);
    chk_digit(384, 1, 8'hB0);
    chk_digit(384, 2, 8'h08);
    chk_digit(384, 3, 8'hF9);

    run_to(512);
    brightness = 4'd3;
    act_cnt    = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (i == 0) check_eq("pwm3_first", {28'd0, SEL}, 32'h1);
      if (SEL != 4'b0000) act_cnt++;
    end
    check_eq("pwm3_on_cycles", act_cnt, 8);
    brightness = 4'd0;
    act_cnt    = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (SEL != 4'b0000) act_cnt++;
    end
    check_eq("pwm0_on_cycles", act_cnt, 2);
    brightness = 4'd15;

    run_to(600);
    do_update(16'h1111, 4'b0000);
    run_to(610);
    do_update(16'h2222, 4'b0000);
    chk_digit(640, 0, 8'hA4);
    chk_digit(640, 1, 8'hA4);
    run_to(767);
    do_update(16'h3333, 4'b0000);
    check_eq("wrapupd_pending", {31'd0, pending}, 32'h1);
    check_eq("wrapupd_fd", {31'd0, frame_done}, 32'h1);
    chk_digit(768, 0, 8'hA4);
    run_to(895);
    check_eq("wrapupd_pend_hold", {31'd0, pending}, 32'h1);
    step();
    check_eq("wrapupd_pend_clr", {31'd0, pending}, 32'h0);
    chk_digit(896, 0, 8'hB0);

    run_to(900);
    do_update(16'h0050, 4'b1000);
    chk_digit(1024, 0, 8'hC0);
    chk_digit(1024, 1, 8'h92);
`ifdef SEG7_LZB_EN
    chk_digit(1024, 2, 8'hFF);
    chk_digit(1024, 3, 8'h7F);
`else
    chk_digit(1024, 2, 8'hC0);
    chk_digit(1024, 3, 8'h40);
`endif
    run_to(1130);
    do_update(16'h0000, 4'b0000);
    chk_digit(1152, 0, 8'hC0);
`ifdef SEG7_LZB_EN
    chk_digit(1152, 1, 8'hFF);
    chk_digit(1152, 3, 8'hFF);
`else
    chk_digit(1152, 1, 8'hC0);
    chk_digit(1152, 3, 8'hC0);
`endif

    run_to(1260);
    do_update(16'h8888, 4'b0000);
    check_eq("rst2_pending_pre", {31'd0, pending}, 32'h1);
    run_to(1270);
    Reset_n = 1'b0;
    #1;
    check_eq("rst2_sel", {28'd0, SEL}, 32'h0);
    check_eq("rst2_seg", {24'd0, SEG}, 32'hFF);
    check_eq("rst2_pending", {31'd0, pending}, 32'h0);
    step();
    check_eq("rst2_sel_hold", {28'd0, SEL}, 32'h0);
    Reset_n = 1'b1;
    cyc     = 0;
    step();
    check_eq("rel_sel", {28'd0, SEL}, 32'h1);
    check_eq("rel_seg", {24'd0, SEG}, 32'hC0);
    run_to(128);
    check_eq("rel_fd", {31'd0, frame_done}, 32'h1);
    check_eq("rel_pending", {31'd0, pending}, 32'h0);
    chk_digit(128, 0, 8'hC0);
    chk_digit(128, 3, 8'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
